// File: rtl/one_scanner_pkg.sv
// Shared types and constants for the one_scanner block.
// ONE_SCANNER_EMPTY_REPORT_EN adds the EMPTY state for all-zero words.
package one_scanner_pkg;

  localparam int DEFAULT_WIDTH = 64;

  function automatic int idxWidth(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1
`ifdef ONE_SCANNER_EMPTY_REPORT_EN
    ,
    EMPTY = 2'd2
`endif
  } state_e;

endpackage

// File: rtl/one_scanner_if.sv
// Word-in / index-out valid-ready bundle for one_scanner.
// out_empty only exists when ONE_SCANNER_EMPTY_REPORT_EN is defined.
interface one_scanner_if
  import one_scanner_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDX_W = idxWidth(WIDTH)
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic             out_last;
`ifdef ONE_SCANNER_EMPTY_REPORT_EN
  logic             out_empty;
`endif

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_index,
    input  out_last
`ifdef ONE_SCANNER_EMPTY_REPORT_EN
    ,
    input  out_empty
`endif
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_index,
    output out_last
`ifdef ONE_SCANNER_EMPTY_REPORT_EN
    ,
    output out_empty
`endif
  );

endinterface

// File: rtl/one_scanner_lsb_priority_enc.sv
// Combinational lowest-set-bit encoder with one-hot and zero flags.
module lsb_priority_enc
  import one_scanner_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDX_W = idxWidth(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] index_o,
  output logic             one_hot_o,
  output logic             zero_o
);

  logic found;

  // Scan from the LSB upward and keep the first hit.
  always_comb begin
    index_o = '0;
    found   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!found && vec_i[i]) begin
        index_o = IDX_W'(i);
        found   = 1'b1;
      end
    end
  end

  // Clearing the lowest set bit leaves zero only when exactly one bit was set.
  assign zero_o    = ~|vec_i;
  assign one_hot_o = !zero_o && ((vec_i & (vec_i - WIDTH'(1))) == '0);

endmodule

// File: rtl/one_scanner.sv
// Streams out the index of every set bit of an accepted word, LSB first.
// ONE_SCANNER_EMPTY_REPORT_EN makes an all-zero word produce one out_empty beat.
module one_scanner
  import one_scanner_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDX_W = idxWidth(WIDTH)
) (
  input  logic           clk,
  input  logic           rst,
  one_scanner_if.slave   bus,
  output logic           busy,
  output logic [IDX_W:0] count
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [IDX_W:0]   count_q, count_d;

  logic [IDX_W-1:0] encIndex;
  logic             encOneHot;
  logic             encZero;

  logic             inReady;
  logic             outValid;
  logic [IDX_W-1:0] outIndex;
  logic             outLast;
  logic             outEmpty;

  lsb_priority_enc #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_enc (
    .vec_i     (shadow_q),
    .index_o   (encIndex),
    .one_hot_o (encOneHot),
    .zero_o    (encZero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      count_q  <= count_d;
    end
  end

  // Outputs derive only from registered state, so out_ready never reaches them.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    count_d  = count_q;
    inReady  = 1'b0;
    outValid = 1'b0;
    outIndex = '0;
    outLast  = 1'b0;
    outEmpty = 1'b0;

    case (state_q)
      IDLE: begin
        inReady = 1'b1;
        if (bus.in_valid) begin
          shadow_d = bus.in_data;
          count_d  = '0;
          if (|bus.in_data) begin
            state_d = SCAN;
          end else begin
`ifdef ONE_SCANNER_EMPTY_REPORT_EN
            state_d = EMPTY;
`else
            state_d = IDLE;
`endif
          end
        end
      end

      SCAN: begin
        outValid = 1'b1;
        outIndex = encIndex;
        outLast  = encOneHot;
        if (bus.out_ready) begin
          shadow_d = shadow_q & ~(WIDTH'(1) << encIndex);
          count_d  = count_q + (IDX_W+1)'(1);
          if (encOneHot || encZero) begin
            state_d = IDLE;
          end
        end
      end

`ifdef ONE_SCANNER_EMPTY_REPORT_EN
      EMPTY: begin
        outValid = 1'b1;
        outEmpty = 1'b1;
        outLast  = 1'b1;
        if (bus.out_ready) begin
          count_d = (IDX_W+1)'(1);
          state_d = IDLE;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid;
  assign bus.out_index = outIndex;
  assign bus.out_last  = outLast;
`ifdef ONE_SCANNER_EMPTY_REPORT_EN
  assign bus.out_empty = outEmpty;
`endif

  assign busy  = (state_q != IDLE);
  assign count = count_q;

endmodule

// File: tb/tb_one_scanner.sv
// Scoreboard bench for one_scanner; expected beats are queued by the stimulus
// and popped by a monitor. Honors ONE_SCANNER_EMPTY_REPORT_EN for zero words.
module tb_one_scanner;

  localparam int WIDTH = 64;
  localparam int IDX_W = 6;

  typedef struct {
    logic [IDX_W-1:0] index;
    logic             last;
    logic             empty;
  } beat_t;

  logic           clk;
  logic           rst;
  logic           busy;
  logic [IDX_W:0] count;

  beat_t expQ[$];
  int    compared = 0;
  int    mismatched = 0;

  one_scanner_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

  one_scanner #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .busy  (busy),
    .count (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic pushBeat(input int idx, input bit last, input bit empty);
    beat_t b;
    b.index = IDX_W'(idx);
    b.last  = last;
    b.empty = empty;
    expQ.push_back(b);
  endtask

  // Returns #1 after the edge that captured the word (start of cycle N+1).
  task automatic applyStimulus(input logic [WIDTH-1:0] word);
    int waited = 0;
    while (!bus.in_ready && waited < 300) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!bus.in_ready) checkOutput("in_ready_timeout", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = word;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (expQ.size() == 0 && !busy) break;
    end
    checkOutput("drain_queue", 64'(expQ.size()), 64'd0);
    checkOutput("drain_busy", 64'(busy), 64'd0);
  endtask

  // Monitor: every handshaken beat must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_beat_idx", 64'(bus.out_index), 64'hFFFF);
      end else begin
        beat_t e;
        e = expQ.pop_front();
        checkOutput("beat_index", 64'(bus.out_index), 64'(e.index));
        checkOutput("beat_last", 64'(bus.out_last), 64'(e.last));
`ifdef ONE_SCANNER_EMPTY_REPORT_EN
        checkOutput("beat_empty", 64'(bus.out_empty), 64'(e.empty));
`endif
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busyCycles;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("reset_count", 64'(count), 64'd0);

    // Single bit at position 50.
    @(posedge clk);
    #1;
    pushBeat(50, 1, 0);
    applyStimulus(64'h0004_0000_0000_0000);
    @(negedge clk);
    checkOutput("t1_valid_n1", 64'(bus.out_valid), 64'd1);
    checkOutput("t1_in_ready_n1", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("t1_in_ready_n2", 64'(bus.in_ready), 64'd1);
    checkOutput("t1_count", 64'(count), 64'd1);

    // Both ends of the word on consecutive cycles.
    pushBeat(0, 0, 0);
    pushBeat(63, 1, 0);
    @(posedge clk);
    #1;
    applyStimulus(64'h8000_0000_0000_0001);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("t2_count", 64'(count), 64'd2);
    checkOutput("t2_in_ready", 64'(bus.in_ready), 64'd1);

    // All ones: 64 beats, busy for exactly 64 cycles.
    for (int i = 0; i < 64; i++) pushBeat(i, (i == 63), 0);
    @(posedge clk);
    #1;
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF);
    busyCycles = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      busyCycles++;
    end
    checkOutput("t3_busy_cycles", 64'(busyCycles), 64'd64);
    checkOutput("t3_count", 64'(count), 64'd64);

    // Stall for 3 cycles with in_valid left high during the scan.
    @(posedge clk);
    #1;
    pushBeat(5, 0, 0);
    pushBeat(7, 1, 0);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 64'h0000_0000_0000_00A0;
    @(posedge clk);
    #1;
    bus.in_data = 64'h0000_0000_0000_0F00;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("t4_stall_index", 64'(bus.out_index), 64'd5);
      checkOutput("t4_stall_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("t4_stall_last", 64'(bus.out_last), 64'd0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("t4_fourth_index", 64'(bus.out_index), 64'd5);
    checkOutput("t4_in_ready_busy", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("t4_second_index", 64'(bus.out_index), 64'd7);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("t4_count", 64'(count), 64'd2);
    checkOutput("t4_busy_done", 64'(busy), 64'd0);

    // Reset while the 10th beat (index 9) is presented.
    for (int i = 0; i < 9; i++) pushBeat(i, 0, 0);
    @(posedge clk);
    #1;
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF);
    repeat (9) @(posedge clk);
    #1;
    checkOutput("t5_tenth_index", 64'(bus.out_index), 64'd9);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t5_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("t5_busy", 64'(busy), 64'd0);
    checkOutput("t5_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("t5_count", 64'(count), 64'd0);
    checkOutput("t5_queue", 64'(expQ.size()), 64'd0);
    pushBeat(1, 1, 0);
    @(posedge clk);
    #1;
    applyStimulus(64'h0000_0000_0000_0002);
    waitDrain();
    checkOutput("t5_fresh_count", 64'(count), 64'd1);

    // All-zero word.
`ifdef ONE_SCANNER_EMPTY_REPORT_EN
    pushBeat(0, 1, 1);
    @(posedge clk);
    #1;
    applyStimulus(64'h0);
    waitDrain();
    checkOutput("t6_count", 64'(count), 64'd1);
`else
    @(posedge clk);
    #1;
    applyStimulus(64'h0);
    @(negedge clk);
    checkOutput("t6_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("t6_busy", 64'(busy), 64'd0);
    checkOutput("t6_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("t6_count", 64'(count), 64'd0);
`endif

    repeat (3) @(posedge clk);
    checkOutput("final_queue", 64'(expQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
